lane_word_packer: RTL and testbench
===================================

// Module: lane_word_packer
// PURPOSE
//  Byte-stream to lane-word packer; the write-side counterpart of the 4x8 lane
//  transform, which consumes a flat 32-bit word and increments each lane.
//  Accepts one LANE_W-bit symbol per valid/ready handshake.
//  Places symbols into lanes 0..N_LANES-1 and optionally removes the +1 lane bias.
//  Emits a flattened word, {lane[N-1],...,lane[1],lane[0]}, on a valid/ready output.
// PARAMETERS
//  LANE_W    8  width of one lane/symbol
//  N_LANES   4  lanes per output word
//  UNDO_INC  1  1: store (s_data - 1) mod 2^LANE_W per lane; 0: store s_data unchanged
// PORTS
//  clk      in   1               single clock, rising edge
//  rst_n    in   1               asynchronous, active-low reset
//  s_data   in   LANE_W          input symbol
//  s_valid  in   1               s_data valid
//  s_last   in   1               symbol ends a packet; closes the word early
//  s_ready  out  1               packer can accept a symbol this cycle
//  m_data   out  LANE_W*N_LANES  packed word; lane k = bits [k*LANE_W +: LANE_W]
//  m_keep   out  N_LANES         bit k = 1: lane k holds a real symbol
//  m_last   out  1               word ends a packet
//  m_valid  out  1               output word valid
//  m_ready  in   1               downstream accepts the word
// BEHAVIOUR
//  - Reset: asynchronous assert, synchronous release.
//    m_valid=0, m_data=0, m_keep=0, m_last=0, lane index idx=0, accumulator=0.
//  - s_ready = !m_valid | m_ready (combinational). An in-progress word stalls only
//    while an undrained word is held.
//  - Input beat: s_valid & s_ready on a rising edge.
//    Lane idx of the accumulator <= f(s_data), where f = -1 mod 2^LANE_W if UNDO_INC.
//    keep bit idx is set.
//  - Word close: a beat with idx==N_LANES-1 or s_last=1. Same edge:
//    m_data <= accumulator including this beat; unfilled lanes are 0.
//    m_keep <= filled lanes; m_last <= s_last; m_valid <= 1.
//    idx <= 0; accumulator and keep are cleared.
//  - Otherwise a beat advances idx by 1.
//  - Latency: m_valid rises on the clock after the closing beat.
//    Sustained rate is one symbol per clock when m_ready=1 (no bubbles).
//  - Output handshake: with m_valid=1 and m_ready=0, m_data/m_keep/m_last/m_valid
//    hold stable.
//    On m_valid & m_ready, m_valid drops next clock unless a new word closes on
//    the same edge, in which case the new word loads and m_valid stays 1.
//  - States (idx + m_valid): EMPTY (idx=0, !m_valid); FILLING (idx>0);
//    HOLD (m_valid), which overlaps FILLING when the accumulator is partially filled.
//  - s_last on the first symbol: one-lane word, m_keep=0001, m_last=1.
//  - s_valid=0: no state change; idx is held indefinitely (no timeout).
//  - Wrap: UNDO_INC maps 0x00 -> 0xFF; no carry between lanes.
//  - Reset mid-word: partial accumulator and any held word are discarded;
//    no output is emitted for them.
//  - s_data/s_last are ignored when s_valid=0 or s_ready=0.
// TESTING
//  1 UNDO_INC=1, m_ready=1, beats 11,22,33,44 (hex)
//    -> one word m_data=0x43322110, m_keep=F, m_last=0; 1 clk after 4th beat.
//  2 Beats 00,01,FF,80 -> m_data=0x7FFE00FF (per-lane wrap, no inter-lane carry).
//  3 Beats A1,B2 with s_last on B2
//    -> m_data=0x0000B1A0, m_keep=3, m_last=1; next word starts at lane 0.
//  4 m_ready=0, 8 beats offered
//    -> first word held stable; s_ready=0 after 4th beat.
//    Release m_ready -> second word completes; both words correct, in order.
//  5 8 beats back-to-back with m_ready=1
//    -> m_valid high on clocks 5 and 9 after the first beat; zero idle cycles on s_ready.
//  6 2 beats, then rst_n low for 1 cycle mid-clock -> outputs zero immediately.
//    Then beats 01,02,03,04 -> m_data=0x03020100, m_keep=F.

Source files
------------

// File: rtl/lane_word_packer.sv
// Byte-stream to lane-word packer: collects LANE_W-bit symbols into N_LANES lanes,
// optionally removing a +1 per-lane bias, and emits words on a valid/ready port.
module lane_word_packer #(
  parameter int LANE_W   = 8,
  parameter int N_LANES  = 4,
  parameter int UNDO_INC = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANE_W-1:0]           s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [LANE_W*N_LANES-1:0]   m_data,
  output logic [N_LANES-1:0]          m_keep,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready
);

  localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  logic [IDX_W-1:0]          idx_q,    idx_d;
  logic [LANE_W*N_LANES-1:0] acc_q,    acc_d;
  logic [N_LANES-1:0]        keep_q,   keep_d;
  logic [LANE_W*N_LANES-1:0] m_data_q, m_data_d;
  logic [N_LANES-1:0]        m_keep_q, m_keep_d;
  logic                      m_last_q, m_last_d;
  logic                      m_valid_q, m_valid_d;

  logic                      beat;
  logic                      close;
  logic [LANE_W-1:0]         sym;
  logic [LANE_W*N_LANES-1:0] acc_ins;
  logic [N_LANES-1:0]        keep_ins;

  assign s_ready = !m_valid_q || m_ready;
  assign beat    = s_valid && s_ready;
  assign close   = beat && ((idx_q == IDX_W'(N_LANES - 1)) || s_last);
  assign sym     = (UNDO_INC != 0) ? (s_data - LANE_W'(1)) : s_data;

  // Accumulator/keep with the current beat merged in; used both to advance and to close.
  always_comb begin
    acc_ins  = acc_q;
    keep_ins = keep_q;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        acc_ins[k*LANE_W +: LANE_W] = sym;
        keep_ins[k]                 = 1'b1;
      end
    end
  end

  always_comb begin
    idx_d     = idx_q;
    acc_d     = acc_q;
    keep_d    = keep_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (close) begin
      m_data_d  = acc_ins;
      m_keep_d  = keep_ins;
      m_last_d  = s_last;
      m_valid_d = 1'b1;
      idx_d     = '0;
      acc_d     = '0;
      keep_d    = '0;
    end else if (beat) begin
      acc_d  = acc_ins;
      keep_d = keep_ins;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      acc_q     <= '0;
      keep_q    <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      keep_q    <= keep_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_lane_word_packer.sv
// Scoreboard bench for lane_word_packer: a symbol-list reference model predicts
// each packed word; an independent monitor compares words as they drain.
module tb_lane_word_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  lane_word_packer #(.LANE_W(8), .N_LANES(4), .UNDO_INC(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_keep (m_keep),
    .m_last (m_last),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  word_t       exp_q[$];
  logic [7:0]  cur[$];
  int          stalls   = 0;
  bit          rand_ready = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: each symbol loses its +1 bias modulo 256; lane k holds symbol k of the word.
  task automatic model_beat(input logic [7:0] d, input logic last);
    word_t w;
    cur.push_back(d);
    if (last || cur.size() == 4) begin
      w.data = '0;
      for (int k = 0; k < cur.size(); k++)
        w.data = w.data + (32'((int'(cur[k]) + 255) % 256) << (8 * k));
      w.keep = 4'((1 << cur.size()) - 1);
      w.last = last;
      exp_q.push_back(w);
      cur.delete();
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [7:0] d, input logic last);
    bit done = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        model_beat(d, last);
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        stalls++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Monitor: pops on every output handshake and checks held words stay stable.
  initial begin
    word_t w;
    word_t held;
    bit    hold_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 0;
      end else begin
        if (hold_prev) begin
          chk("hold_stable", {m_valid, m_data, m_keep, m_last},
              {1'b1, held.data, held.keep, held.last});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {m_data, m_keep, m_last}, 64'd0);
          end else begin
            w = exp_q.pop_front();
            chk("word", {m_data, m_keep, m_last}, {w.data, w.keep, w.last});
          end
        end
        hold_prev = m_valid && !m_ready;
        held      = '{data: m_data, keep: m_keep, last: m_last};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drain(input string name);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #12;
    chk("reset_outputs", {m_valid, m_data, m_keep, m_last, s_ready},
        {1'b0, 32'd0, 4'd0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic word and one-clock latency
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    chk("t1_no_early_valid", 64'(m_valid), 64'd0);
    send(8'h44, 0);
    chk("t1_latency", {m_valid, m_data, m_keep, m_last}, {1'b1, 32'h43322110, 4'hF, 1'b0});

    // 2: per-lane wrap
    send(8'h00, 0); send(8'h01, 0); send(8'hFF, 0); send(8'h80, 0);
    chk("t2_wrap", 64'(m_data), 64'h7FFE00FF);

    // 3: early close, then a one-lane packet from lane 0
    send(8'hA1, 0); send(8'hB2, 1);
    chk("t3_short", {m_data, m_keep, m_last}, {32'h0000B1A0, 4'h3, 1'b1});
    send(8'hC3, 1);
    chk("t3_one_lane", {m_data, m_keep, m_last}, {32'h000000C2, 4'h1, 1'b1});
    drain("t3_drain");

    // 4: backpressure
    m_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(8'(i * 8'h11), 0);
      end
    join_none
    repeat (10) @(posedge clk);
    #1;
    chk("t4_stall", {s_ready, m_valid, m_data}, {1'b0, 1'b1, 32'h43322110});
    m_ready = 1'b1;
    wait fork;
    chk("t4_second", {m_valid, m_data}, {1'b1, 32'h87766554});
    drain("t4_drain");

    // 5: back-to-back beats, no bubbles, valid on the closing beats only
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), 0);
      chk("t5_valid_timing", 64'(m_valid), 64'(i % 4 == 3));
    end
    chk("t5_no_stalls", 64'(stalls), 64'd0);
    drain("t5_drain");

    // 6: reset mid-word discards partial state
    send(8'h5A, 0); send(8'h6B, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_async", {m_valid, m_data, m_keep, m_last}, 38'd0);
    cur.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    chk("t6_after_reset", {m_data, m_keep}, {32'h03020100, 4'hF});
    drain("t6_drain");

    // Randomized traffic with random backpressure and idle gaps
    rand_ready = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom), (i == 199) || ($urandom_range(0, 3) == 0));
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    drain("rand_drain");
    chk("model_empty", 64'(cur.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
